// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and the IF/ID record shared by the fetch and decode stages.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int IMEM_DEPTH = 255;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     inst;
        logic            valid;
        logic            fault;
    } if_id_t;
    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0, fault: 1'b0};
endpackage

// File: rtl/fetch_if.sv
// fetch_if: control inputs, instruction-memory port and IF/ID outputs of the fetch stage.
interface fetch_if #(parameter int WIDTH = 32);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] count;
    logic [31:0]      instt;
    logic [WIDTH-1:0] if_id_pc;
    logic [WIDTH-1:0] if_id_pc4;
    logic [31:0]      if_id_inst;
    logic             if_id_valid;
    logic             fetch_fault;
    modport master (
        input  stall, redirect, redirect_pc, instt,
        output count, if_id_pc, if_id_pc4, if_id_inst, if_id_valid, fetch_fault
    );
    modport slave (
        output stall, redirect, redirect_pc, instt,
        input  count, if_id_pc, if_id_pc4, if_id_inst, if_id_valid, fetch_fault
    );
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with hold and flush-to-bubble; flush beats hold.
module if_id_reg import fetch_pkg::*; #(
    parameter int           W      = $bits(if_id_t),
    parameter logic [W-1:0] BUBBLE = IF_ID_BUBBLE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      q <= BUBBLE;
        else if (flush)  q <= BUBBLE;
        else if (!hold)  q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and fetch-window check feeding the IF/ID register.
module fetch_stage import fetch_pkg::*; #(
    parameter int               WIDTH      = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int               IMEM_DEPTH = fetch_pkg::IMEM_DEPTH
) (
    input logic      clk,
    input logic      rst_n,
    fetch_if.master  bus
);
    localparam logic [WIDTH-1:0] LIMIT = RESET_PC + WIDTH'(4 * IMEM_DEPTH);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             mis_q, mis_d, ok;
    if_id_t           d, q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    // The misaligned flag marks the first slot fetched after a redirect to an unaligned target.
    always_comb begin
        ok      = pc_q >= RESET_PC && pc_q < LIMIT && !mis_q;
        pc_d    = bus.redirect ? {bus.redirect_pc[WIDTH-1:2], 2'b00} : bus.stall ? pc_q : pc_q + WIDTH'(4);
        mis_d   = bus.redirect ? |bus.redirect_pc[1:0] : bus.stall ? mis_q : 1'b0;
        d.pc    = pc_q;
        d.pc4   = pc_q + WIDTH'(4);
        d.inst  = ok ? bus.instt : NOP_INST;
        d.valid = ok;
        d.fault = !ok;
    end
    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (bus.stall & ~bus.redirect),
        .flush (bus.redirect),
        .d     (d),
        .q     (q)
    );
    assign bus.count       = pc_q;
    assign bus.if_id_pc    = q.pc;
    assign bus.if_id_pc4   = q.pc4;
    assign bus.if_id_inst  = q.inst;
    assign bus.if_id_valid = q.valid;
    assign bus.fetch_fault = q.fault;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a behavioural fetch model.
module tb_fetch_stage;
    import fetch_pkg::*;
    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] count;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        fault;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] mem [0:254];
    int passed = 0;
    int total = 0;
    vec_t tbl[$];
    logic [31:0] m_pc;
    logic        m_mis;
    if_id_t      m_ifid;
    fetch_if #(.WIDTH(32)) bus ();
    fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] imem(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - RESET_PC;
        return off < 32'd1020 ? mem[off[31:2]] : (32'hBAD0_0000 ^ addr);
    endfunction
    assign bus.instt = imem(bus.count);
    function automatic logic [129:0] snap();
        return {bus.count, bus.if_id_pc, bus.if_id_pc4, bus.if_id_inst, bus.if_id_valid, bus.fetch_fault};
    endfunction
    task automatic check(input string nm, input logic [129:0] got, input logic [129:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", nm, got, exp);
        else passed++;
    endtask
    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        bus.stall = s;
        bus.redirect = r;
        bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask
    // Model: a slot is good only when its offset from the base lies inside the memory and no unaligned redirect preceded it.
    task automatic model_edge(input logic s, input logic r, input logic [31:0] rpc);
        logic good;
        if (r) begin
            m_ifid = IF_ID_BUBBLE;
            m_mis = rpc[1:0] != 2'b00;
            m_pc = rpc & 32'hFFFF_FFFC;
        end else if (!s) begin
            good = (m_pc - RESET_PC) < 32'd1020 && !m_mis;
            m_ifid = '{pc: m_pc, pc4: m_pc + 32'd4, inst: good ? imem(m_pc) : NOP_INST, valid: good, fault: !good};
            m_mis = 1'b0;
            m_pc = m_pc + 32'd4;
        end
    endtask
    initial begin
        logic [31:0] ep4;
        logic [31:0] rpc;
        logic s, r;
        for (int i = 0; i < 255; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        mem[16] = 32'h1616; mem[17] = 32'h1717; mem[32] = 32'h3232;
        tbl.push_back('{0, 0, 0, 32'h8000_0004, 32'h8000_0000, 32'h11, 1, 0});
        tbl.push_back('{0, 0, 0, 32'h8000_0008, 32'h8000_0004, 32'h22, 1, 0});
        tbl.push_back('{1, 0, 0, 32'h8000_0008, 32'h8000_0004, 32'h22, 1, 0});
        tbl.push_back('{1, 0, 0, 32'h8000_0008, 32'h8000_0004, 32'h22, 1, 0});
        tbl.push_back('{1, 0, 0, 32'h8000_0008, 32'h8000_0004, 32'h22, 1, 0});
        tbl.push_back('{0, 0, 0, 32'h8000_000C, 32'h8000_0008, 32'h33, 1, 0});
        tbl.push_back('{0, 1, 32'h8000_0040, 32'h8000_0040, 0, NOP_INST, 0, 0});
        tbl.push_back('{0, 0, 0, 32'h8000_0044, 32'h8000_0040, 32'h1616, 1, 0});
        tbl.push_back('{1, 1, 32'h8000_0080, 32'h8000_0080, 0, NOP_INST, 0, 0});
        tbl.push_back('{1, 0, 0, 32'h8000_0080, 0, NOP_INST, 0, 0});
        tbl.push_back('{0, 0, 0, 32'h8000_0084, 32'h8000_0080, 32'h3232, 1, 0});
        tbl.push_back('{0, 1, 32'h8000_0042, 32'h8000_0040, 0, NOP_INST, 0, 0});
        tbl.push_back('{0, 0, 0, 32'h8000_0044, 32'h8000_0040, NOP_INST, 0, 1});
        tbl.push_back('{0, 0, 0, 32'h8000_0048, 32'h8000_0044, 32'h1717, 1, 0});
        tbl.push_back('{0, 1, 32'h8000_03FC, 32'h8000_03FC, 0, NOP_INST, 0, 0});
        tbl.push_back('{0, 0, 0, 32'h8000_0400, 32'h8000_03FC, NOP_INST, 0, 1});
        tbl.push_back('{0, 1, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 0, NOP_INST, 0, 0});
        tbl.push_back('{0, 0, 0, 32'h8000_0000, 32'h7FFF_FFFC, NOP_INST, 0, 1});
        tbl.push_back('{0, 0, 0, 32'h8000_0004, 32'h8000_0000, 32'h11, 1, 0});
        tbl.push_back('{0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, NOP_INST, 0, 0});
        tbl.push_back('{0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, NOP_INST, 0, 1});
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        #12 rst_n = 1'b1;
        #1 check("reset", snap(), {RESET_PC, 32'h0, 32'h0, NOP_INST, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            step(tbl[i].stall, tbl[i].redirect, tbl[i].rpc);
            ep4 = (tbl[i].valid || tbl[i].fault) ? tbl[i].pc + 32'd4 : 32'h0;
            check($sformatf("vec%0d", i), snap(), {tbl[i].count, tbl[i].pc, ep4, tbl[i].inst, tbl[i].valid, tbl[i].fault});
        end
        step(0, 1, 32'h8000_0010);
        step(0, 0, 0);
        step(0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", snap(), {RESET_PC, 32'h0, 32'h0, NOP_INST, 1'b0, 1'b0});
        #2 rst_n = 1'b1;
        m_pc = RESET_PC;
        m_mis = 1'b0;
        m_ifid = IF_ID_BUBBLE;
        for (int n = 0; n < 300; n++) begin
            s = $urandom_range(0, 3) == 0;
            r = $urandom_range(0, 9) == 0;
            case ($urandom_range(0, 3))
                0: rpc = RESET_PC + ($urandom_range(0, 254) << 2);
                1: rpc = RESET_PC + $urandom_range(0, 1019);
                2: rpc = RESET_PC + 32'd1020 + ($urandom_range(0, 15) << 2);
                default: rpc = $urandom;
            endcase
            step(s, r, rpc);
            model_edge(s, r, rpc);
            check($sformatf("rand%0d", n), snap(), {m_pc, m_ifid.pc, m_ifid.pc4, m_ifid.inst, m_ifid.valid, m_ifid.fault});
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly upstream of `instruction_memory`. It holds the program counter, drives it as the byte address `count` into the combinational instruction memory, and takes back the 32-bit word `instt`. It registers that word with its PC into an IF/ID pipeline register for the decode stage. It handles stall, branch/jump redirect, and out-of-range fetch faults.

## Interface
- `WIDTH`, 32: address/data width.
- `RESET_PC`, 32'h8000_0000: first fetch address; also the instruction-memory base.
- `IMEM_DEPTH`, 255: instruction-memory depth in words; sets the valid fetch window.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold the PC and the IF/ID register (hazard from decode).
- `redirect`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  WIDTH  redirect target byte address.
- `count`  out  WIDTH  current PC to the instruction memory.
- `instt`  in  32  instruction word returned for `count`.
- `if_id_pc`  out  WIDTH  PC of the registered instruction.
- `if_id_pc4`  out  WIDTH  `if_id_pc` + 4.
- `if_id_inst`  out  32  registered instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_fault`  out  1  registered instruction slot came from an out-of-range or misaligned PC.

## Operation
- `count` = `pc_q`, driven combinationally from the PC register. `instt` is sampled in the same cycle.
- The fetch window is in range when `RESET_PC` <= `pc_q` < `RESET_PC` + 4*`IMEM_DEPTH`, using unsigned compare.
- Next-PC priority, evaluated every edge: redirect > stall > sequential.
  - `redirect`=1: `pc_q` <= {`redirect_pc`[WIDTH-1:2], 2'b00}. IF/ID loads a bubble (valid 0, inst NOP 32'h0000_0013), which flushes the wrong-path fetch. The misaligned flag is set if `redirect_pc`[1:0] != 0.
  - `stall`=1, no redirect: `pc_q`, IF/ID and the flag all hold.
  - Otherwise: `pc_q` <= `pc_q` + 4, modulo 2^WIDTH, so 32'hFFFF_FFFC wraps to 0. IF/ID loads {`pc_q`, `pc_q`+4, `instt`}.
    - If the window is in range and the misaligned flag is clear: valid 1, fault 0.
    - Otherwise: inst NOP, valid 0, fault 1. The misaligned flag clears after this load.
- Redirect together with stall: redirect wins and the stall is ignored for that edge.
- Reset mid-operation: all state returns to reset values immediately; no partial update survives.
- Reset values: `pc_q`=`RESET_PC` (so `count`=`RESET_PC`), `if_id_pc`=0, `if_id_pc4`=0, `if_id_inst`=32'h0000_0013, `if_id_valid`=0, `fetch_fault`=0, misaligned flag 0.

## Timing
- The instruction at PC N appears on IF/ID outputs 1 edge after `count`=N with no stall. Steady-state throughput is 1 instruction/cycle.
- The first valid IF/ID entry appears at the first rising edge after `rst_n` deasserts: PC `RESET_PC`, valid 1.
- Redirect penalty is 1 bubble. At edge E (redirect sampled), IF/ID gets a bubble. At E+1, IF/ID gets the target instruction.
- A stall asserted for k cycles freezes all outputs for k edges. Sequential flow resumes on the first edge with `stall`=0.
- The memory path is combinational: `count` -> `instt` -> IF/ID D input must close within one cycle.

## Structure
- Shared package `fetch_pkg` holds:
  - the `RESET_PC` and `NOP_INST` (32'h0000_0013) constants;
  - the `if_id_t` packed struct {pc, pc4, inst, valid, fault}, reused by the decode stage.
- One natural sub-module is `if_id_reg`. It is the IF/ID register with hold (stall) and flush (load bubble) controls, async active-low reset to the bubble value, and it is reused for later pipeline registers.
- The PC register, next-PC mux and range/alignment check stay in `fetch_stage`.

## Test plan
- Reset then free-run with memory words 0x11,0x22,0x33 at 0x8000_0000/4/8:
  - `count` steps by 4 each cycle;
  - IF/ID shows (0x8000_0000,0x11), then (0x8000_0004,0x22), then (0x8000_0008,0x33), each valid 1.
- Stall for 3 cycles while `count`=0x8000_0008: `count` and IF/ID are unchanged for 3 edges, then 0x8000_0008's word is loaded.
- Redirect to 0x8000_0040 while `count`=0x8000_000C: the next IF/ID entry is valid 0 with NOP, then (0x8000_0040, word16) valid 1.
- Redirect together with stall: redirect wins, and `count`=target on the next cycle.
- Redirect to 0x8000_0042: `count`=0x8000_0040, and the target's IF/ID entry has valid 0 and fault 1.
- Redirect to 0x8000_03FC (beyond 255 words) and to 0x7FFF_FFFC: both IF/ID entries have valid 0, fault 1, inst NOP.
- Assert `rst_n`=0 mid-stream asynchronously (between edges): `count`=0x8000_0000 and `if_id_valid`=0 immediately.
